dma_dsc_out_crd_arb: RTL and testbench

Parametrised multi-channel descriptor-output credit arbiter. It accepts descriptor blocks from `NUM_CHN` independent sources and keeps a per-channel credit counter that the downstream descriptor sink replenishes. Each cycle it round-robin grants one credited, enabled channel and presents the descriptor on a single registered output. It sits between the descriptor engines and the PCIe descriptor-out sink. It replaces the single-channel credit/descriptor pairing with channel-tagged credits, saturation and error reporting.

---
 rtl/dma_dsc_out_crd_arb.sv | 200 ++++++++++++++++++++
 tb/tb_dma_dsc_out_crd_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_dsc_out_crd_arb.sv
// ---------------------------------------------------------------------------
// dma_dsc_out_crd_arb
//
// Multi-channel descriptor-output credit arbiter. Each source channel owns a
// credit counter that the downstream descriptor sink replenishes through
// channel-tagged credit returns. Every cycle one enabled, valid and credited
// channel is granted in round-robin order and its descriptor is presented on
// a single registered output port.
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   chn_en       - per-channel enable (disabled channels are never granted)
//   in_dsc_vld   - per-channel descriptor valid
//   in_dsc_rdy   - per-channel accept (combinational one-hot grant or zero)
//   in_dsc_data  - per-channel descriptors, channel i at [i*DSC_W +: DSC_W]
//   out_dsc_vld  - registered descriptor valid (sink is credit flow-controlled)
//   out_dsc_data - registered descriptor
//   out_dsc_chn  - source channel of out_dsc_data
//   crd_vld      - credit return strobe
//   crd_chn      - channel receiving the returned credits
//   crd_num      - number of credits returned (0 is a no-op)
//   crd_cnt      - packed credit counters, channel i at [i*CRD_W +: CRD_W]
//   crd_err      - sticky error: counter saturation or out-of-range crd_chn
// ---------------------------------------------------------------------------
module dma_dsc_out_crd_arb #(
    parameter int NUM_CHN   = 4,
    parameter int DSC_W     = 256,
    parameter int CRD_W     = 8,
    parameter int CRD_INC_W = 4,
    parameter int INIT_CRD  = 4,
    parameter int CHN_W     = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CHN-1:0]       chn_en,
    input  logic [NUM_CHN-1:0]       in_dsc_vld,
    output logic [NUM_CHN-1:0]       in_dsc_rdy,
    input  logic [NUM_CHN*DSC_W-1:0] in_dsc_data,
    output logic                     out_dsc_vld,
    output logic [DSC_W-1:0]         out_dsc_data,
    output logic [CHN_W-1:0]         out_dsc_chn,
    input  logic                     crd_vld,
    input  logic [CHN_W-1:0]         crd_chn,
    input  logic [CRD_INC_W-1:0]     crd_num,
    output logic [NUM_CHN*CRD_W-1:0] crd_cnt,
    output logic                     crd_err
);

    localparam logic [CRD_W:0]   CRD_MAX   = {1'b0, {CRD_W{1'b1}}};
    localparam logic [CRD_W:0]   CRD_ONE   = {{CRD_W{1'b0}}, 1'b1};
    localparam logic [CRD_W-1:0] CRD_INIT  = CRD_W'(INIT_CRD);
    localparam logic [CHN_W-1:0] PTR_INIT  = CHN_W'(NUM_CHN - 1);
    localparam logic [CHN_W:0]   NUM_CHN_W = (CHN_W + 1)'(NUM_CHN);

    logic [CRD_W-1:0]   cnt_r [NUM_CHN];
    logic [CRD_W-1:0]   cnt_nxt_s [NUM_CHN];
    logic [CHN_W-1:0]   rr_ptr_r;
    logic [NUM_CHN-1:0] elig_s;
    logic [NUM_CHN-1:0] grant_s;
    logic               grant_any_s;
    logic [CHN_W-1:0]   grant_idx_s;
    logic               xfer_s;
    logic [DSC_W-1:0]   sel_data_s;
    logic               sat_s;
    logic               ret_bad_s;
    logic               out_vld_r;
    logic [DSC_W-1:0]   out_data_r;
    logic [CHN_W-1:0]   out_chn_r;
    logic               err_r;

    // Eligibility: enabled, presenting a descriptor and holding at least one credit.
    always_comb begin
        elig_s = {NUM_CHN{1'b0}};
        for (int i = 0; i < NUM_CHN; i++) begin
            elig_s[i] = chn_en[i] & in_dsc_vld[i] & (cnt_r[i] != {CRD_W{1'b0}});
        end
    end

    // Round-robin search starting one past the last granted channel.
    // Depends only on registered counters/pointer and same-cycle vld/en, so
    // a credit return cannot reach in_dsc_rdy in the cycle it arrives.
    always_comb begin
        logic [CHN_W:0]   idx_w;
        logic [CHN_W-1:0] idx_c;
        idx_w       = {(CHN_W + 1){1'b0}};
        idx_c       = {CHN_W{1'b0}};
        grant_any_s = 1'b0;
        grant_idx_s = {CHN_W{1'b0}};
        grant_s     = {NUM_CHN{1'b0}};
        for (int k = 1; k <= NUM_CHN; k++) begin
            idx_w = {1'b0, rr_ptr_r} + (CHN_W + 1)'(k);
            if (idx_w >= NUM_CHN_W) begin
                idx_w = idx_w - NUM_CHN_W;
            end else begin
                idx_w = idx_w;
            end
            idx_c = idx_w[CHN_W-1:0];
            if (!grant_any_s && elig_s[idx_c]) begin
                grant_any_s = 1'b1;
                grant_idx_s = idx_c;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        // Reset masks the grant so nothing is accepted while the block is held.
        if (grant_any_s && !rst) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NUM_CHN{1'b0}};
        end
    end

    assign xfer_s     = |grant_s;
    assign in_dsc_rdy = grant_s;

    // One-hot AND-OR mux of the granted channel's descriptor.
    always_comb begin
        sel_data_s = {DSC_W{1'b0}};
        for (int i = 0; i < NUM_CHN; i++) begin
            if (grant_s[i]) begin
                sel_data_s = sel_data_s | in_dsc_data[i*DSC_W +: DSC_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Credit arithmetic one bit wider than the counter: issue and return on
    // the same channel net out, and overflow saturates and flags an error.
    always_comb begin
        logic [CRD_W:0] sum_v;
        sum_v     = {(CRD_W + 1){1'b0}};
        sat_s     = 1'b0;
        ret_bad_s = crd_vld & ({1'b0, crd_chn} >= NUM_CHN_W);
        for (int i = 0; i < NUM_CHN; i++) begin
            sum_v = {1'b0, cnt_r[i]};
            // A granted channel always has cnt >= 1, so this cannot underflow.
            if (grant_s[i]) begin
                sum_v = sum_v - CRD_ONE;
            end else begin
                sum_v = sum_v;
            end
            if (crd_vld && (crd_chn == CHN_W'(i))) begin
                sum_v = sum_v + (CRD_W + 1)'(crd_num);
            end else begin
                sum_v = sum_v;
            end
            if (sum_v > CRD_MAX) begin
                cnt_nxt_s[i] = CRD_MAX[CRD_W-1:0];
                sat_s        = 1'b1;
            end else begin
                cnt_nxt_s[i] = sum_v[CRD_W-1:0];
            end
        end
    end

    // State: credit counters, round-robin pointer, output register, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHN; i++) begin
                cnt_r[i] <= CRD_INIT;
            end
            rr_ptr_r   <= PTR_INIT;
            out_vld_r  <= 1'b0;
            out_data_r <= {DSC_W{1'b0}};
            out_chn_r  <= {CHN_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            out_vld_r <= xfer_s;
            if (xfer_s) begin
                rr_ptr_r   <= grant_idx_s;
                out_data_r <= sel_data_s;
                out_chn_r  <= grant_idx_s;
            end else begin
                rr_ptr_r   <= rr_ptr_r;
                out_data_r <= out_data_r;
                out_chn_r  <= out_chn_r;
            end
            err_r <= err_r | sat_s | ret_bad_s;
        end
    end

    // Pack the counters onto the flat status port.
    always_comb begin
        crd_cnt = {(NUM_CHN * CRD_W){1'b0}};
        for (int i = 0; i < NUM_CHN; i++) begin
            crd_cnt[i*CRD_W +: CRD_W] = cnt_r[i];
        end
    end

    assign out_dsc_vld  = out_vld_r;
    assign out_dsc_data = out_data_r;
    assign out_dsc_chn  = out_chn_r;
    assign crd_err      = err_r;

endmodule

// File: tb/tb_dma_dsc_out_crd_arb.sv
// ---------------------------------------------------------------------------
// Testbench for dma_dsc_out_crd_arb. The main instance uses the default
// parameters (4 channels, INIT_CRD=4, CRD_W=8); a second 3-channel instance
// exercises an out-of-range credit-return channel index.
// ---------------------------------------------------------------------------
module tb_dma_dsc_out_crd_arb;

    localparam int NUM_CHN = 4;
    localparam int DSC_W   = 256;
    localparam int CHN_W   = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_CHN-1:0]       chn_en;
    logic [NUM_CHN-1:0]       in_dsc_vld;
    logic [NUM_CHN-1:0]       in_dsc_rdy;
    logic [NUM_CHN*DSC_W-1:0] in_dsc_data;
    logic                     out_dsc_vld;
    logic [DSC_W-1:0]         out_dsc_data;
    logic [CHN_W-1:0]         out_dsc_chn;
    logic                     crd_vld;
    logic [CHN_W-1:0]         crd_chn;
    logic [3:0]               crd_num;
    logic [NUM_CHN*8-1:0]     crd_cnt;
    logic                     crd_err;

    logic [2:0]  chn_en3;
    logic [2:0]  in_dsc_vld3;
    logic [2:0]  in_dsc_rdy3;
    logic [47:0] in_dsc_data3;
    logic        out_dsc_vld3;
    logic [15:0] out_dsc_data3;
    logic [1:0]  out_dsc_chn3;
    logic        crd_vld3;
    logic [1:0]  crd_chn3;
    logic [3:0]  crd_num3;
    logic [23:0] crd_cnt3;
    logic        crd_err3;

    int checks;
    int errors;
    int stamp;
    logic [CHN_W-1:0] exp_q[$];
    logic [CHN_W-1:0] exp_ch;

    dma_dsc_out_crd_arb #(.NUM_CHN(4), .DSC_W(256), .CRD_W(8), .CRD_INC_W(4), .INIT_CRD(4)) u_dut (
        .clk(clk), .rst(rst), .chn_en(chn_en), .in_dsc_vld(in_dsc_vld), .in_dsc_rdy(in_dsc_rdy),
        .in_dsc_data(in_dsc_data), .out_dsc_vld(out_dsc_vld), .out_dsc_data(out_dsc_data),
        .out_dsc_chn(out_dsc_chn), .crd_vld(crd_vld), .crd_chn(crd_chn), .crd_num(crd_num),
        .crd_cnt(crd_cnt), .crd_err(crd_err)
    );

    dma_dsc_out_crd_arb #(.NUM_CHN(3), .DSC_W(16), .CRD_W(8), .CRD_INC_W(4), .INIT_CRD(4)) u_dut3 (
        .clk(clk), .rst(rst), .chn_en(chn_en3), .in_dsc_vld(in_dsc_vld3), .in_dsc_rdy(in_dsc_rdy3),
        .in_dsc_data(in_dsc_data3), .out_dsc_vld(out_dsc_vld3), .out_dsc_data(out_dsc_data3),
        .out_dsc_chn(out_dsc_chn3), .crd_vld(crd_vld3), .crd_chn(crd_chn3), .crd_num(crd_num3),
        .crd_cnt(crd_cnt3), .crd_err(crd_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Descriptor contents encode the channel and the cycle stamp they were driven in.
    function automatic logic [DSC_W-1:0] mk_data(input int ch, input int s);
        logic [DSC_W-1:0] v;
        v = {DSC_W{1'b0}};
        v[7:0] = 8'(ch);
        v[39:8] = 32'(s);
        v[DSC_W-1:DSC_W-32] = 32'hD5C0_0000 ^ 32'(ch);
        return v;
    endfunction

    task drive_data;
        for (int ch = 0; ch < NUM_CHN; ch++) in_dsc_data[ch*DSC_W +: DSC_W] = mk_data(ch, stamp);
        in_dsc_data3 = {16'(stamp), 16'(stamp), 16'(stamp)};
    endtask

    task tick;
        @(posedge clk);
        #1;
        stamp = stamp + 1;
        drive_data();
    endtask

    task clear_inputs;
        chn_en = 4'b1111; in_dsc_vld = 4'b0000; crd_vld = 1'b0; crd_chn = 2'd0; crd_num = 4'd0;
        chn_en3 = 3'b111; in_dsc_vld3 = 3'b000; crd_vld3 = 1'b0; crd_chn3 = 2'd0; crd_num3 = 4'd0;
    endtask

    task do_reset;
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Every output descriptor must match the oldest expected entry; data is
    // the one driven in the cycle before the output appeared.
    always @(negedge clk) begin
        if (out_dsc_vld === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got chn %0d, expected no output", out_dsc_chn);
            end else begin
                exp_ch = exp_q.pop_front();
                if (out_dsc_chn !== exp_ch || out_dsc_data !== mk_data(int'(exp_ch), stamp - 1)) begin
                    errors++;
                    $display("FAIL out_dsc: got chn %0d data %0h, expected chn %0d data %0h",
                             out_dsc_chn, out_dsc_data[39:0], exp_ch, mk_data(int'(exp_ch), stamp - 1) & 40'hFF_FFFF_FFFF);
                end
            end
        end
    end

    task drain(input string name);
        tick(); tick();
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d outputs still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task test_reset;
        rst = 1'b1;
        chn_en = 4'b1111; in_dsc_vld = 4'b1111; crd_vld = 1'b1; crd_chn = 2'd1; crd_num = 4'd5;
        chn_en3 = 3'b111; in_dsc_vld3 = 3'b111; crd_vld3 = 1'b1; crd_chn3 = 2'd3; crd_num3 = 4'd5;
        #1;
        checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy0: got %b expected 0000", in_dsc_rdy); end
        tick(); tick();
        checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", in_dsc_rdy); end
        checks++; if (out_dsc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", out_dsc_vld); end
        checks++; if (out_dsc_chn !== 2'd0 || out_dsc_data !== {DSC_W{1'b0}}) begin errors++; $display("FAIL reset_out: got chn %0d data %0h expected 0", out_dsc_chn, out_dsc_data[31:0]); end
        checks++; if (crd_cnt !== 32'h0404_0404) begin errors++; $display("FAIL reset_cnt: got %h expected 04040404", crd_cnt); end
        checks++; if (crd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", crd_err); end
        checks++; if (crd_cnt3 !== 24'h04_0404 || crd_err3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got cnt %h err %b expected 040404 0", crd_cnt3, crd_err3); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task test_credit_exhaust;
        do_reset();
        in_dsc_vld = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1; checks++; if (in_dsc_rdy !== 4'b0001) begin errors++; $display("FAIL exhaust_rdy%0d: got %b expected 0001", i, in_dsc_rdy); end
            exp_q.push_back(2'd0);
            tick();
        end
        #1;
        checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL exhaust_rdy_empty: got %b expected 0000", in_dsc_rdy); end
        checks++; if (crd_cnt[7:0] !== 8'd0) begin errors++; $display("FAIL exhaust_cnt: got %0d expected 0", crd_cnt[7:0]); end
        tick(); tick();
        crd_vld = 1'b1; crd_chn = 2'd0; crd_num = 4'd2;
        #1; checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL exhaust_ret_same_cycle: got %b expected 0000", in_dsc_rdy); end
        tick();
        crd_vld = 1'b0; crd_num = 4'd0;
        #1;
        checks++; if (crd_cnt[7:0] !== 8'd2) begin errors++; $display("FAIL exhaust_ret_cnt: got %0d expected 2", crd_cnt[7:0]); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (in_dsc_rdy !== 4'b0001) begin errors++; $display("FAIL exhaust_ret_rdy%0d: got %b expected 0001", i, in_dsc_rdy); end
            exp_q.push_back(2'd0);
            tick(); #1;
        end
        checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL exhaust_again: got %b expected 0000", in_dsc_rdy); end
        tick(); tick();
        in_dsc_vld = 4'b0000;
        drain("exhaust");
    endtask

    task test_round_robin;
        logic [CHN_W-1:0] seq [10];
        seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        do_reset();
        in_dsc_vld = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) chn_en[1] = 1'b0;
            #1; checks++;
            if (in_dsc_rdy !== (4'b0001 << seq[i])) begin errors++; $display("FAIL rr_grant%0d: got %b expected ch %0d", i, in_dsc_rdy, seq[i]); end
            exp_q.push_back(seq[i]);
            tick();
        end
        #1;
        checks++; if (crd_cnt !== 32'h0004_0200) begin errors++; $display("FAIL rr_cnt: got %h expected 00040200", crd_cnt); end
        // Disabled channel keeps and still accepts credits.
        crd_vld = 1'b1; crd_chn = 2'd1; crd_num = 4'd1;
        tick();
        crd_vld = 1'b0; crd_num = 4'd0;
        #1;
        checks++; if (crd_cnt[15:8] !== 8'd3 || in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL rr_disabled_ret: got cnt %0d rdy %b expected 3 0000", crd_cnt[15:8], in_dsc_rdy); end
        in_dsc_vld = 4'b0000;
        chn_en = 4'b1111;
        drain("rr");
    endtask

    task test_simul_issue_return;
        do_reset();
        in_dsc_vld = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'd2);
            tick();
        end
        #1;
        checks++; if (crd_cnt[23:16] !== 8'd1) begin errors++; $display("FAIL simul_pre_cnt: got %0d expected 1", crd_cnt[23:16]); end
        crd_vld = 1'b1; crd_chn = 2'd2; crd_num = 4'd3;
        checks++; if (in_dsc_rdy !== 4'b0100) begin errors++; $display("FAIL simul_rdy: got %b expected 0100", in_dsc_rdy); end
        exp_q.push_back(2'd2);
        tick();
        crd_vld = 1'b0; crd_num = 4'd0;
        #1;
        checks++; if (crd_cnt[23:16] !== 8'd3) begin errors++; $display("FAIL simul_cnt: got %0d expected 3", crd_cnt[23:16]); end
        checks++; if (in_dsc_rdy !== 4'b0100) begin errors++; $display("FAIL simul_regrant: got %b expected 0100", in_dsc_rdy); end
        exp_q.push_back(2'd2);
        tick();
        in_dsc_vld = 4'b0000;
        #1;
        checks++; if (crd_cnt[23:16] !== 8'd2) begin errors++; $display("FAIL simul_post_cnt: got %0d expected 2", crd_cnt[23:16]); end
        drain("simul");
    endtask

    task test_saturation;
        do_reset();
        crd_vld = 1'b1; crd_chn = 2'd0; crd_num = 4'd15;
        repeat (16) tick();
        crd_num = 4'd6;
        tick();
        crd_vld = 1'b0; crd_num = 4'd0;
        #1;
        checks++; if (crd_cnt[7:0] !== 8'd250 || crd_err !== 1'b0) begin errors++; $display("FAIL sat_pre: got cnt %0d err %b expected 250 0", crd_cnt[7:0], crd_err); end
        crd_vld = 1'b1; crd_num = 4'd15;
        tick();
        crd_vld = 1'b0; crd_num = 4'd0;
        #1;
        checks++; if (crd_cnt[7:0] !== 8'd255 || crd_err !== 1'b1) begin errors++; $display("FAIL sat_hit: got cnt %0d err %b expected 255 1", crd_cnt[7:0], crd_err); end
        tick(); tick();
        checks++; if (crd_err !== 1'b1 || crd_cnt !== 32'h0404_04FF) begin errors++; $display("FAIL sat_sticky: got err %b cnt %h expected 1 040404ff", crd_err, crd_cnt); end
        // Out-of-range channel on the 3-channel instance.
        checks++; if (crd_err3 !== 1'b0) begin errors++; $display("FAIL bad_chn_pre: got %b expected 0", crd_err3); end
        crd_vld3 = 1'b1; crd_chn3 = 2'd3; crd_num3 = 4'd5;
        tick();
        crd_vld3 = 1'b0; crd_num3 = 4'd0;
        #1;
        checks++; if (crd_err3 !== 1'b1 || crd_cnt3 !== 24'h04_0404) begin errors++; $display("FAIL bad_chn: got err %b cnt %h expected 1 040404", crd_err3, crd_cnt3); end
        crd_vld3 = 1'b1; crd_chn3 = 2'd2; crd_num3 = 4'd1;
        tick();
        crd_vld3 = 1'b0; crd_num3 = 4'd0;
        #1;
        checks++; if (crd_err3 !== 1'b1 || crd_cnt3 !== 24'h05_0404) begin errors++; $display("FAIL bad_chn_after: got err %b cnt %h expected 1 050404", crd_err3, crd_cnt3); end
    endtask

    task test_reset_midstream;
        logic [CHN_W-1:0] seq [4];
        seq = '{2'd0, 2'd1, 2'd0, 2'd1};
        do_reset();
        in_dsc_vld = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(seq[i]);
            tick();
        end
        #1;
        checks++; if (crd_cnt !== 32'h0404_0202 || out_dsc_vld !== 1'b1) begin errors++; $display("FAIL mid_pre: got cnt %h vld %b expected 04040202 1", crd_cnt, out_dsc_vld); end
        rst = 1'b1;
        #1;
        checks++; if (in_dsc_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rdy_rst: got %b expected 0000", in_dsc_rdy); end
        tick();
        checks++; if (out_dsc_vld !== 1'b0 || crd_cnt !== 32'h0404_0404) begin errors++; $display("FAIL mid_reset: got vld %b cnt %h expected 0 04040404", out_dsc_vld, crd_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (in_dsc_rdy !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", in_dsc_rdy); end
        exp_q.push_back(2'd0);
        tick();
        in_dsc_vld = 4'b0000;
        drain("mid");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stamp  = 0;
        rst    = 1'b1;
        clear_inputs();
        drive_data();
        test_reset();
        test_credit_exhaust();
        test_round_robin();
        test_simul_issue_return();
        test_saturation();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
